// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: fetch PC generator, 1-cycle-latency imem request port
// and a DEPTH-entry prefetch queue handing instructions to ID over valid/ready.
module if_prefetch_stage #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      PC_STEP  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       branch_taken_i,
    input  logic [WIDTH-1:0]           branch_addr_i,
    output logic                       imem_req_o,
    output logic [WIDTH-1:0]           imem_addr_o,
    input  logic [WIDTH-1:0]           imem_rdata_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           instruction_o,
    output logic [WIDTH-1:0]           pc_adder_out_o,
    output logic [$clog2(DEPTH):0]     occupancy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);
    localparam logic [CW:0]      DEPTH_W = (CW+1)'(DEPTH);

    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [WIDTH-1:0] pcn_q   [DEPTH];

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             pop;
    logic             push;
    logic             issue;
    logic [CW:0]      credit;

    assign out_valid_o = rst_i & (count_q != '0) & ~branch_taken_i;
    assign pop         = out_valid_o & out_ready_i;
    assign push        = inflight_q & ~branch_taken_i;

    // Entries already held plus the one in flight, minus what leaves this cycle,
    // must leave room for the response of a new request.
    assign credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign issue  = rst_i & ~branch_taken_i & (credit < DEPTH_W);

    assign imem_req_o     = issue;
    assign imem_addr_o    = fetch_pc_q;
    assign instruction_o  = instr_q[rd_ptr_q];
    assign pc_adder_out_o = pcn_q[rd_ptr_q];
    assign occupancy_o    = count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (branch_taken_i) begin
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            inflight_d = 1'b0;
            fetch_pc_d = branch_addr_i;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + STEP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (rst_i && push) begin
            instr_q[wr_ptr_q] <= imem_rdata_i;
            pcn_q[wr_ptr_q]   <= inflight_pc_q + STEP;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: queue-based reference model compared every cycle,
// directed scenarios pinned with literal values, then a randomized soak.
module tb_if_prefetch_stage;

    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] STEP     = 32'd4;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic          clk = 1'b0;
    logic          rst;
    logic          branchTaken;
    logic [31:0]   branchAddr;
    logic          imemReq;
    logic [31:0]   imemAddr;
    logic [31:0]   imemRdata;
    logic          outValid;
    logic          outReady;
    logic [31:0]   instruction;
    logic [31:0]   pcAdderOut;
    logic [CW-1:0] occupancy;

    always #5 clk = ~clk;

    if_prefetch_stage #(
        .WIDTH(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(RESET_PC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .branch_taken_i(branchTaken),
        .branch_addr_i(branchAddr),
        .imem_req_o(imemReq),
        .imem_addr_o(imemAddr),
        .imem_rdata_i(imemRdata),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .instruction_o(instruction),
        .pc_adder_out_o(pcAdderOut),
        .occupancy_o(occupancy)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcn;
    } entry_t;

    entry_t      mQ[$];
    logic [31:0] mFetchPc    = RESET_PC;
    logic [31:0] mInflightPc = RESET_PC;
    bit          mInflight   = 1'b0;

    int errors = 0;
    int checks = 0;

    bit          lastReq  = 1'b0;
    logic [31:0] lastAddr = '0;

    bit          sValid, sReq;
    logic [31:0] sAddr, sInstr, sPcn;
    int          sOcc;
    bit          eValid, eReq, ePop;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int size;
        size   = mQ.size();
        sValid = outValid;
        sReq   = imemReq;
        sAddr  = imemAddr;
        sInstr = instruction;
        sPcn   = pcAdderOut;
        sOcc   = int'(occupancy);

        eValid = rst && (size != 0) && !branchTaken;
        ePop   = eValid && outReady;
        eReq   = rst && !branchTaken && ((size + int'(mInflight) - int'(ePop)) < DEPTH);

        cmp("out_valid", 32'(sValid), 32'(eValid));
        cmp("imem_req", 32'(sReq), 32'(eReq));
        cmp("occupancy", 32'(sOcc), 32'(size));
        checks++;
        if (sOcc > DEPTH) begin
            errors++;
            $display("[TB] FAIL overflow: occupancy %0d, limit %0d at %0t", sOcc, DEPTH, $time);
        end
        if (eReq) cmp("imem_addr", sAddr, mFetchPc);
        if (eValid) begin
            cmp("instruction", sInstr, mQ[0].instr);
            cmp("pc_adder_out", sPcn, mQ[0].pcn);
        end
        lastReq  = sReq;
        lastAddr = sAddr;
    endtask

    task automatic updateModel();
        entry_t e;
        if (!rst) begin
            mQ.delete();
            mInflight = 1'b0;
            mFetchPc  = RESET_PC;
        end else if (branchTaken) begin
            mQ.delete();
            mInflight = 1'b0;
            mFetchPc  = branchAddr;
        end else begin
            if (ePop) void'(mQ.pop_front());
            if (mInflight) begin
                e.instr = memf(mInflightPc);
                e.pcn   = mInflightPc + STEP;
                mQ.push_back(e);
            end
            mInflight = eReq;
            if (eReq) begin
                mInflightPc = mFetchPc;
                mFetchPc    = mFetchPc + STEP;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit b, input logic [31:0] ba, input bit rdy);
        rst         = r;
        branchTaken = b;
        branchAddr  = ba;
        outReady    = rdy;
        imemRdata   = lastReq ? memf(lastAddr) : $urandom();
        @(negedge clk);
        checkOutput();
        updateModel();
        @(posedge clk);
        #1;
    endtask

    task automatic fillTo(input int target, input bit needInflight);
        int n;
        n = 0;
        while (!(mQ.size() == target && (mInflight || !needInflight)) && n < 20) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("[TB] FAIL fill timeout: occupancy %0d, wanted %0d", mQ.size(), target);
        end
    endtask

    initial begin
        rst = 1'b0; branchTaken = 1'b0; branchAddr = '0; outReady = 1'b0; imemRdata = '0;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        cmp("reset out_valid", 32'(sValid), 32'd0);
        cmp("reset occupancy", 32'(sOcc), 32'd0);
        cmp("reset imem_req", 32'(sReq), 32'd0);

        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("first req", 32'(sReq), 32'd1);
        cmp("first addr", sAddr, 32'h0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("second addr", sAddr, 32'h4);
        cmp("T+1 out_valid", 32'(sValid), 32'd0);
        for (int j = 2; j < 10; j++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b1);
            cmp("stream valid", 32'(sValid), 32'd1);
            cmp("stream pc_adder_out", sPcn, 32'(4 * (j - 1)));
        end

        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
        cmp("backpressure occupancy", 32'(sOcc), 32'(DEPTH));
        cmp("backpressure imem_req", 32'(sReq), 32'd0);
        for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, '0, 1'b1);

        applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
        fillTo(3, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1);
        cmp("branch out_valid", 32'(sValid), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("B+1 occupancy", 32'(sOcc), 32'd0);
        cmp("B+1 addr", sAddr, 32'h100);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("B+2 out_valid", 32'(sValid), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("B+3 out_valid", 32'(sValid), 32'd1);
        cmp("B+3 pc_adder_out", sPcn, 32'h104);

        fillTo(3, 1'b0);
        for (int k = 0; k < 6 * DEPTH * 2; k++) applyStimulus(1'b1, 1'b0, '0, bit'(k % 2));

        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("wrap addr 0", sAddr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("wrap addr 1", sAddr, 32'h0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("wrap pc_adder_out", sPcn, 32'h0);

        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0);
        fillTo(2, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        cmp("in-reset imem_req", 32'(sReq), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("post-reset out_valid", 32'(sValid), 32'd0);
        cmp("post-reset occupancy", 32'(sOcc), 32'd0);
        cmp("post-reset addr", sAddr, RESET_PC);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        cmp("post-reset pc_adder_out", sPcn, 32'h4);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] ba;
            ba = $urandom();
            if ($urandom_range(1) == 0) ba[1:0] = 2'b00;
            applyStimulus($urandom_range(99) != 0, $urandom_range(15) == 0, ba,
                          (k / 200) % 2 == 0 ? $urandom_range(3) != 0 : $urandom_range(3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with a decoupled prefetch queue. It replaces the single-register fetch path with three parts: a fetch PC generator, a fixed 1-cycle-latency instruction-memory request port, and a DEPTH-entry FIFO. The FIFO hands instructions to the ID stage over a valid/ready handshake. A taken branch flushes the queue, squashes any in-flight fetch and redirects the PC. The block sits between the PC/branch logic of the EX stage and the IF/ID pipeline register.

## Interface
- WIDTH, 32: PC, address and instruction width.
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- PC_STEP, 4: PC increment per sequential fetch.
- RESET_PC, 0: first fetch address after reset.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low (reset when rst==0 at a rising clk edge).
- branch_taken  input  1  redirect request from EX.
- branch_addr  input  WIDTH  redirect target; sampled when branch_taken==1.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  WIDTH  fetch address; meaningful only when imem_req==1.
- imem_rdata  input  WIDTH  instruction data, valid exactly 1 cycle after its imem_req.
- out_valid  output  1  head of queue is presented.
- out_ready  input  1  ID stage accepts the head this cycle.
- instruction  output  WIDTH  head instruction.
- pc_adder_out  output  WIDTH  head instruction address + PC_STEP.
- occupancy  output  clog2(DEPTH)+1  current queue entry count.

## Operation
- State:
  - fetch_pc register.
  - inflight flag, set when a request was issued last cycle and not squashed.
  - queue storage with rd_ptr/wr_ptr of clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
  - inflight_pc register.
- Pop: pop = out_valid & out_ready. out_valid = (count != 0) & ~branch_taken.
- Issue: imem_req = ~branch_taken & (count + inflight − pop < DEPTH). imem_addr = fetch_pc. On issue, fetch_pc ← fetch_pc + PC_STEP, wrapping modulo 2^WIDTH.
- Response: when inflight==1 and no branch_taken this cycle, push {imem_rdata, inflight_pc + PC_STEP} at wr_ptr.
- Credit check: push never occurs into a full queue. Overflow is a design error; the bench asserts against it.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pop with an empty queue is impossible, because out_valid==0.
- Flush: when branch_taken==1 at an edge:
  - count ← 0 and rd_ptr ← wr_ptr.
  - inflight ← 0; a response arriving this cycle is dropped.
  - fetch_pc ← branch_addr; no request is issued this cycle.
  - branch_taken has priority over push, pop and issue.
- Back-to-back branch_taken: each one re-targets fetch_pc, and the last one wins.

## Timing
- Reset (rst==0 at an edge): fetch_pc←RESET_PC, count←0, pointers←0, inflight←0.
- Outputs during and after reset, before the first fetch:
  - out_valid=0, occupancy=0.
  - imem_req=0 while rst==0.
  - instruction and pc_adder_out are don't-care while out_valid==0.
- Reset mid-operation discards queue contents and the in-flight fetch identically to a flush, and returns fetch_pc to RESET_PC.
- First request: cycle T, the first cycle with rst==1, imem_req=1 and imem_addr=RESET_PC.
  - Data arrives at T+1 and is pushed at the end of T+1.
  - out_valid=1 at T+2.
  - Fetch-to-output latency is 2 cycles.
- Steady-state throughput is 1 instruction per cycle for any DEPTH≥2 while out_ready==1.
- Redirect: branch_taken in cycle B.
  - imem_req=1 with imem_addr=branch_addr at B+1.
  - The first target instruction has out_valid=1 at B+3.
- Backpressure: with out_ready==0, the queue fills to DEPTH and then imem_req stays 0. Contents and head stay stable until a pop.
- Handshake: instruction and pc_adder_out remain stable while out_valid==1 and out_ready==0, unless a flush or reset occurs.

## Test plan
- Reset, then out_ready=1 continuously:
  - imem_req=1 with imem_addr = 0, 4, 8, … on consecutive cycles.
  - out_valid rises 2 cycles after the first request.
  - pc_adder_out = 4, 8, 12, …, one per cycle with no bubbles.
- Backpressure, DEPTH=4: hold out_ready=0.
  - occupancy reaches 4 and imem_req drops to 0 with no overflow.
  - Release out_ready: 4 instructions drain in order, then fetch resumes at the next sequential PC.
- Branch with queue holding 3 entries plus one in flight: branch_taken=1, branch_addr=0x100.
  - out_valid=0 in the branch cycle.
  - occupancy=0 the next cycle; the in-flight data is never output.
  - imem_addr=0x100 at B+1; the first output has pc_adder_out=0x104 at B+3.
- Simultaneous push and pop at occupancy=DEPTH−1 with alternating out_ready:
  - occupancy never exceeds DEPTH.
  - Order is preserved across rd_ptr/wr_ptr wrap, checked over at least 3·DEPTH instructions.
- PC wrap: branch_addr=0xFFFF_FFFC.
  - Fetch addresses run 0xFFFF_FFFC, then 0x0000_0000.
  - pc_adder_out of the first instruction is 0x0000_0000.
- Reset asserted mid-stream with occupancy=2 and a fetch in flight:
  - Next cycle: out_valid=0, occupancy=0.
  - After release, fetch restarts at RESET_PC.
